// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX message arbiter.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ = 2;
    localparam int unsigned IDX_W       = $clog2(DEF_NUM_REQ);
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned MAX_IDX_W   = 3;

    // Index of the set bit in a one-hot vector (all-zero input yields 0).
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            idx = idx | ({MAX_IDX_W{oh[i]}} & MAX_IDX_W'(i));
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the TX FIFO write side, as seen by the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 fifo_full;
    logic                 fifo_push;
    logic [7:0]           fifo_wdata;

    modport master (
        input  req, req_data, req_last, fifo_full,
        output req_ack, fifo_push, fifo_wdata
    );

    modport slave (
        output req, req_data, req_last, fifo_full,
        input  req_ack, fifo_push, fifo_wdata
    );
endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: first requester after last_grant_i, wrapping modulo NUM_REQ.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_grant_i,
    output logic               found_o,
    output logic [NUM_REQ-1:0] pick_o
);

    logic [IW-1:0] pos_s;

    // Walk the requesters starting just after the previous owner.
    always_comb begin
        found_o = 1'b0;
        pick_o  = '0;
        pos_s   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos_s         = IW'((32'(last_grant_i) + k) % NUM_REQ);
            pick_o[pos_s] = pick_o[pos_s] | (req_i[pos_s] & ~found_o);
            found_o       = found_o | req_i[pos_s];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter for the UART TX FIFO push port.
// Optional grant revocation on a stalled owner is built with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    uart_tx_arbiter_if.master    bus,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      last_grant_q;

    logic               found_s;
    logic [NUM_REQ-1:0] pick_s;
    logic [MAX_REQ-1:0] grant_ext_s;
    logic [IW-1:0]      owner_idx_s;
    logic               cur_req_s;
    logic               cur_last_s;
    logic               push_s;
    logic [7:0]         wdata_s;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i        (bus.req),
        .last_grant_i (last_grant_q),
        .found_o      (found_s),
        .pick_o       (pick_s)
    );

    // Owner-side view: its request, last flag and data; grant_q is zero outside XFER.
    always_comb begin
        grant_ext_s                = '0;
        grant_ext_s[NUM_REQ-1:0]   = grant_q;
        owner_idx_s                = IW'(onehot2idx(grant_ext_s));
        cur_req_s                  = |(bus.req & grant_q);
        cur_last_s                 = |(bus.req_last & grant_q);
        wdata_s                    = 8'h00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            wdata_s = wdata_s | (bus.req_data[8*i +: 8] & {8{grant_q[i]}});
        end
        push_s = (state_q == XFER) & cur_req_s & ~bus.fifo_full;
    end

    assign bus.fifo_push  = push_s;
    assign bus.fifo_wdata = wdata_s;
    assign bus.req_ack    = push_s ? grant_q : '0;
    assign grant_o        = grant_q;
    assign busy_o         = (state_q == XFER);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    logic          stall_s;

    assign stall_s   = ~cur_req_s & ~bus.fifo_full;
    assign timeout_o = timeout_q;
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout_o = 1'b0;
`endif

    // Arbitration FSM: grant is held until the owner's last byte is pushed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        grant_q <= pick_s;
                        state_q <= XFER;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    if (push_s && cur_last_s) begin
                        last_grant_q <= owner_idx_s;
                        grant_q      <= '0;
                        state_q      <= IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (push_s) begin
                        cnt_q <= '0;
                    end else if (stall_s) begin
                        // The pulse lands in the first IDLE cycle, so nothing is pushed with it.
                        if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                            timeout_q    <= 1'b1;
                            last_grant_q <= owner_idx_s;
                            grant_q      <= '0;
                            state_q      <= IDLE;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`endif
                    end else begin
                        state_q <= XFER;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: message framing, round robin, stall, async reset.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [NR-1:0] grant_o;
    logic          busy_o;
    logic          timeout_o;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .bus       (bus),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic go();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic status(input string tag, input logic push, input logic [1:0] ack,
                          input logic [1:0] grant, input logic busy, input logic tmo);
        chk({tag, "_push"},  32'(bus.fifo_push), 32'(push));
        chk({tag, "_ack"},   32'(bus.req_ack),   32'(ack));
        chk({tag, "_grant"}, 32'(grant_o),       32'(grant));
        chk({tag, "_busy"},  32'(busy_o),        32'(busy));
        chk({tag, "_tmo"},   32'(timeout_o),     32'(tmo));
    endtask

    task automatic present(input int r, input logic [7:0] d, input logic l);
        bus.req[r]             = 1'b1;
        bus.req_data[8*r +: 8] = d;
        bus.req_last[r]        = l;
    endtask

    task automatic xfer(input string tag, input int r, input logic [7:0] d, input logic l);
        logic [1:0] oh;
        oh = 2'b01 << r;
        present(r, d, l);
        smp();
        status(tag, 1'b1, oh, oh, 1'b1, 1'b0);
        chk({tag, "_wdata"}, 32'(bus.fifo_wdata), 32'(d));
        go();
        bus.req[r]      = 1'b0;
        bus.req_last[r] = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        smp();
        status(tag, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        go();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        go();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni        = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;

        smp();
        status("rst", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        go();
        go();
        rst_ni = 1'b1;

        // Message "12\r\n" from requester 0.
        present(0, 8'h31, 1'b0);
        idle_chk("t1_arb");
        xfer("t1_b0", 0, 8'h31, 1'b0);
        xfer("t1_b1", 0, 8'h32, 1'b0);
        xfer("t1_b2", 0, 8'h0D, 1'b0);
        xfer("t1_b3", 0, 8'h0A, 1'b1);
        idle_chk("t1_end");

        // Both requesters pending after reset: req0 first, one gap, then req1.
        do_reset();
        present(0, 8'hA0, 1'b0);
        present(1, 8'hB0, 1'b0);
        idle_chk("t2_arb");
        xfer("t2_a0", 0, 8'hA0, 1'b0);
        xfer("t2_a1", 0, 8'hA1, 1'b1);
        idle_chk("t2_gap");
        xfer("t2_b0", 1, 8'hB0, 1'b0);
        xfer("t2_b1", 1, 8'hB1, 1'b1);
        idle_chk("t2_end");

        // FIFO full for five cycles in mid-message.
        present(0, 8'hC0, 1'b0);
        idle_chk("t3_arb");
        xfer("t3_c0", 0, 8'hC0, 1'b0);
        present(0, 8'hC1, 1'b0);
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            status("t3_stall", 1'b0, 2'b00, 2'b01, 1'b1, 1'b0);
            go();
        end
        bus.fifo_full = 1'b0;
        xfer("t3_c1", 0, 8'hC1, 1'b0);
        xfer("t3_c2", 0, 8'hC2, 1'b1);
        idle_chk("t3_end");

        // Asynchronous reset after byte 2 of 4.
        present(0, 8'hD0, 1'b0);
        idle_chk("t4_arb");
        xfer("t4_d0", 0, 8'hD0, 1'b0);
        xfer("t4_d1", 0, 8'hD1, 1'b0);
        present(0, 8'hD2, 1'b0);
        present(1, 8'hE0, 1'b1);
        #2;
        chk("t4_pre_push", 32'(bus.fifo_push), 32'd1);
        rst_ni = 1'b0;
        #1;
        status("t4_async", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        smp();
        status("t4_hold", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        go();
        rst_ni = 1'b1;
        idle_chk("t4_rel");
        smp();
        status("t4_win0", 1'b1, 2'b01, 2'b01, 1'b1, 1'b0);
        chk("t4_win0_wdata", 32'(bus.fifo_wdata), 32'h0000_00D2);
        rst_ni = 1'b0;
        bus.req[0]      = 1'b0;
        bus.req_last[0] = 1'b0;
        go();
        rst_ni = 1'b1;
        idle_chk("t4_rel2");
        xfer("t4_win1", 1, 8'hE0, 1'b1);
        idle_chk("t4_end");

        // Back-to-back single-byte messages from req1.
        present(1, 8'h41, 1'b1);
        idle_chk("t6_arb");
        xfer("t6_b0", 1, 8'h41, 1'b1);
        present(1, 8'h42, 1'b1);
        idle_chk("t6_gap");
        xfer("t6_b1", 1, 8'h42, 1'b1);
        idle_chk("t6_end");

`ifdef UART_ARB_TIMEOUT_EN
        // Owner goes silent after one byte; grant is revoked after TO stall cycles.
        do_reset();
        present(0, 8'h50, 1'b0);
        present(1, 8'h60, 1'b1);
        idle_chk("t5_arb");
        xfer("t5_b0", 0, 8'h50, 1'b0);
        for (int i = 0; i < int'(TO); i++) begin
            smp();
            status("t5_stall", 1'b0, 2'b00, 2'b01, 1'b1, 1'b0);
            go();
        end
        smp();
        status("t5_pulse", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        go();
        xfer("t5_next", 1, 8'h60, 1'b1);
        idle_chk("t5_end");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Message-granular round-robin arbiter that shares the single UART TX FIFO push port between several byte-stream requesters. Typical requesters are the RX-to-TX echo path and the counter status reporter. Each requester presents bytes with a `last` marker. Once a requester is granted, it keeps the TX path until its `last` byte is accepted, so messages never interleave. The block sits between the requesters and the TX FIFO write side (`wdata`/`push`/`full`).

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `TIMEOUT_CYC`, 1000, requester-stall cycles before a grant is revoked (only with `UART_ARB_TIMEOUT_EN`)

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_REQ  per-requester byte valid
- `req_data`  in  NUM_REQ*8  per-requester byte, requester i at bits [8i+7:8i]
- `req_last`  in  NUM_REQ  byte is last of message
- `req_ack`  out  NUM_REQ  byte of requester i consumed this cycle
- `fifo_full`  in  1  TX FIFO full
- `fifo_push`  out  1  TX FIFO write strobe
- `fifo_wdata`  out  8  TX FIFO write data
- `grant`  out  NUM_REQ  one-hot current owner, registered
- `busy`  out  1  message in progress
- `timeout`  out  1  one-cycle pulse on grant revocation

## Operation
- The FSM has two states, IDLE and XFER.
- **IDLE:**
  - `fifo_push`=0.
  - If any `req` is high, the round-robin picker selects the first requesting index after `last_grant`, with modular wrap.
  - `grant` is loaded with the selected index and the FSM moves to XFER.
  - If no `req` is high, the FSM stays in IDLE.
- **XFER (owner g):**
  - `fifo_push` = `req[g]` & ~`fifo_full`.
  - `fifo_wdata` = `req_data[g]`.
  - `req_ack[g]` = `fifo_push`.
  - All other acks are 0.
  - When `fifo_push` & `req_last[g]`: `last_grant`←g, `grant`←0, FSM→IDLE.
- `req` of non-owners is ignored while in XFER. Requesters hold `req`/data/`last` stable until acked.
- `req_last` is only sampled together with an accepted byte.
- A single-byte message is a byte presented with `req_last`=1 and is legal.
- When `fifo_full` is high, the arbiter stalls indefinitely: no push, no ack, no timeout counting.
- Requesters that drop `req` mid-message keep ownership. Recovery from this case exists only with the timeout feature.
- **Reset (asynchronous, any state):**
  - FSM=IDLE.
  - `grant`=0, `busy`=0, `timeout`=0.
  - `last_grant`=NUM_REQ-1, so index 0 wins the first arbitration.
  - The timeout counter is cleared.
  - `fifo_push` and `req_ack` go to 0 immediately.
  - A partially sent message is abandoned.

## Timing
- Arbitration latency: `req` high in IDLE at cycle n → `grant` valid at n+1 → first push possible at n+1.
- Throughput inside a message: one byte per cycle while `req[g]`=1 and `fifo_full`=0.
- There is exactly one IDLE cycle between consecutive messages, including messages from the same requester.
- `fifo_push`, `fifo_wdata` and `req_ack` are combinational from `req`/`fifo_full`/`grant`. There is no combinational path from `req` to `grant`.
- `busy` equals (state==XFER).

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter of width $clog2(TIMEOUT_CYC+1) increments each XFER cycle with `req[g]`=0 and `fifo_full`=0.
  - The counter clears on every accepted byte and on entry to XFER.
  - When the count reaches TIMEOUT_CYC: `timeout` pulses for 1 cycle, `last_grant`←g, FSM→IDLE.
  - No byte is pushed in the timeout cycle.
- **Undefined:**
  - No counter is built.
  - `timeout` is tied 0.
  - A stalled owner holds the grant until it resumes or reset.

## Structure
- Package `uart_arb_pkg` holds:
  - state enum `arb_state_t` {IDLE, XFER}
  - default `NUM_REQ`
  - index width `IDX_W` = $clog2(NUM_REQ)
  - function `onehot2idx`
- Sub-module `uart_rr_pick` is the combinational rotate-priority encoder. Inputs: `req` vector, `last_grant` index. Outputs: `found`, one-hot pick.

## Test plan
- Reset, then req[0] sends message "12\r\n" (0x31,0x32,0x0D,0x0A, last on 0x0A) → grant=01 one cycle later, 4 pushes on consecutive cycles, then IDLE.
- req[0] and req[1] both high from reset with 2-byte messages each → order req0 msg, one idle cycle, req1 msg; the bytes of the two messages never interleave.
- `fifo_full` asserted for 5 cycles in mid-message → no push/ack during those cycles, `timeout` never fires, the transfer resumes with the same byte.
- Asynchronous reset asserted mid-message after byte 2 of 4 → push/ack drop immediately, grant=0. After release, req1 wins over req0 per reset `last_grant`=NUM_REQ-1 rules only if req0 is absent; otherwise req0 wins.
- With `UART_ARB_TIMEOUT_EN`, TIMEOUT_CYC=8: owner drops `req` after 1 byte → `timeout` pulses exactly 8 cycles later, the other pending requester is granted the next cycle.
- req1 sends back-to-back single-byte messages 0x41, 0x42 with req0 idle → pushes at cycles n+1 and n+3.
